// File: rtl/aes_sbox_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_sbox_arbiter : round-robin sharing of one forward AES S-box between the |
// | SubBytes state path and the SubWord key path. Option: AES_SBOX_ARB_PIPE_EN. |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+

module aes_sbox_canright (
   input  logic [7:0] data_i,
   output logic [7:0] data_o
);
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = '0;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

   // Multiplicative inverse as x^254 (maps 0 to 0), then the affine transform.
   always_comb begin
      x2     = gf_mul(data_i, data_i);
      x3     = gf_mul(x2, data_i);
      x6     = gf_mul(x3, x3);
      x12    = gf_mul(x6, x6);
      x15    = gf_mul(x12, x3);
      x30    = gf_mul(x15, x15);
      x60    = gf_mul(x30, x30);
      x120   = gf_mul(x60, x60);
      x240   = gf_mul(x120, x120);
      x252   = gf_mul(x240, x12);
      inv    = gf_mul(x252, x2);
      data_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end
endmodule

module aes_sbox_arbiter #(
   parameter int NumStateBytes = 16,
   parameter int NumKeyBytes   = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       state_req_i,
   input  logic [8*NumStateBytes-1:0] state_data_i,
   output logic                       state_ack_o,
   output logic [8*NumStateBytes-1:0] state_data_o,
   input  logic                       key_req_i,
   input  logic [8*NumKeyBytes-1:0]   key_data_i,
   output logic                       key_ack_o,
   output logic [8*NumKeyBytes-1:0]   key_data_o,
   output logic                       busy_o
);
   localparam int CNT_W = (NumStateBytes > 1) ? $clog2(NumStateBytes) : 1;
   localparam int SW    = 8 * NumStateBytes;
   localparam int KW    = 8 * NumKeyBytes;
   localparam logic [CNT_W-1:0] STATE_LAST = CNT_W'(NumStateBytes - 1);
   localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(NumKeyBytes - 1);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      BUSY_STATE = 3'd1,
      BUSY_KEY   = 3'd2,
      DONE_STATE = 3'd3,
      DONE_KEY   = 3'd4
   } arb_state_e;

   arb_state_e       st_q, st_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SW-1:0]    buf_q, buf_d;
   logic [SW-1:0]    sout_q, sout_d;
   logic [KW-1:0]    kout_q, kout_d;
   logic             last_key_q, last_key_d;

   logic [7:0]       sbox_in, sbox_out, wr_byte;
   logic [CNT_W-1:0] wr_idx;
   logic             is_key, busy, active, at_last, wr_en, finish, advance;

   assign is_key  = (st_q == BUSY_KEY);
   assign busy    = (st_q == BUSY_STATE) || (st_q == BUSY_KEY);
   assign active  = busy && (is_key ? key_req_i : state_req_i);
   assign at_last = (cnt_q == (is_key ? KEY_LAST : STATE_LAST));
   assign sbox_in = is_key ? key_data_i[{cnt_q, 3'b000} +: 8]
                           : state_data_i[{cnt_q, 3'b000} +: 8];

   aes_sbox_canright u_sbox (
      .data_i (sbox_in),
      .data_o (sbox_out)
   );

`ifdef AES_SBOX_ARB_PIPE_EN
   logic [7:0]       pipe_q;
   logic [CNT_W-1:0] pipe_idx_q;
   logic             pipe_vld_q, drain_q, drain_d, feed;

   // After the last byte is fed, one drain cycle retires it from the pipe.
   assign feed    = active && !drain_q;
   assign drain_d = active && at_last;
   assign wr_en   = active && pipe_vld_q;
   assign wr_idx  = pipe_idx_q;
   assign wr_byte = pipe_q;
   assign finish  = active && drain_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pipe_q     <= '0;
         pipe_idx_q <= '0;
         pipe_vld_q <= 1'b0;
         drain_q    <= 1'b0;
      end else begin
         pipe_vld_q <= feed;
         pipe_idx_q <= cnt_q;
         drain_q    <= drain_d;
         if (feed) pipe_q <= sbox_out;
      end
   end
`else
   assign wr_en   = active;
   assign wr_idx  = cnt_q;
   assign wr_byte = sbox_out;
   assign finish  = active && at_last;
`endif

   assign advance = active && !at_last;

   always_comb begin
      st_d       = st_q;
      cnt_d      = cnt_q;
      buf_d      = buf_q;
      sout_d     = sout_q;
      kout_d     = kout_q;
      last_key_d = last_key_q;
      if (wr_en) buf_d[{wr_idx, 3'b000} +: 8] = wr_byte;
      if (advance) cnt_d = cnt_q + 1'b1;
      case (st_q)
         IDLE: begin
            // Tie goes to whichever side was not granted last.
            if (state_req_i && (!key_req_i || last_key_q)) begin
               st_d       = BUSY_STATE;
               cnt_d      = '0;
               last_key_d = 1'b0;
            end else if (key_req_i) begin
               st_d       = BUSY_KEY;
               cnt_d      = '0;
               last_key_d = 1'b1;
            end
         end
         BUSY_STATE: begin
            if (!state_req_i) begin
               st_d = IDLE;
            end else if (finish) begin
               st_d   = DONE_STATE;
               sout_d = buf_d;
            end
         end
         BUSY_KEY: begin
            if (!key_req_i) begin
               st_d = IDLE;
            end else if (finish) begin
               st_d   = DONE_KEY;
               kout_d = buf_d[KW-1:0];
            end
         end
         DONE_STATE, DONE_KEY: st_d = IDLE;
         default:              st_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         st_q       <= IDLE;
         cnt_q      <= '0;
         buf_q      <= '0;
         sout_q     <= '0;
         kout_q     <= '0;
         last_key_q <= 1'b1;
      end else begin
         st_q       <= st_d;
         cnt_q      <= cnt_d;
         buf_q      <= buf_d;
         sout_q     <= sout_d;
         kout_q     <= kout_d;
         last_key_q <= last_key_d;
      end
   end

   assign state_ack_o  = (st_q == DONE_STATE);
   assign key_ack_o    = (st_q == DONE_KEY);
   assign state_data_o = sout_q;
   assign key_data_o   = kout_q;
   assign busy_o       = (st_q != IDLE);
endmodule

`default_nettype wire

// File: tb/tb_aes_sbox_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_aes_sbox_arbiter : directed self-checking bench for aes_sbox_arbiter.   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_aes_sbox_arbiter;
   localparam int NS = 16;
   localparam int NK = 4;
`ifdef AES_SBOX_ARB_PIPE_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   localparam logic [127:0] ZERO_IN  = 128'h0;
   localparam logic [127:0] ZERO_OUT = {16{8'h63}};
   localparam logic [127:0] SEQ_IN   = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] SEQ_OUT  = 128'h76abd7fe2b670130c56f6bf27b777c63;
   localparam logic [31:0]  KEY_A_IN  = 32'h53020100;
   localparam logic [31:0]  KEY_A_OUT = 32'hed777c63;
   localparam logic [31:0]  KEY_B_IN  = 32'h13121110;
   localparam logic [31:0]  KEY_B_OUT = 32'h7dc982ca;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          state_req_i;
   logic [127:0]  state_data_i;
   logic          state_ack_o;
   logic [127:0]  state_data_o;
   logic          key_req_i;
   logic [31:0]   key_data_i;
   logic          key_ack_o;
   logic [31:0]   key_data_o;
   logic          busy_o;

   int errors = 0;
   int checks = 0;

   always #5 clk_i = ~clk_i;

   aes_sbox_arbiter #(.NumStateBytes(NS), .NumKeyBytes(NK)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .state_req_i  (state_req_i),
      .state_data_i (state_data_i),
      .state_ack_o  (state_ack_o),
      .state_data_o (state_data_o),
      .key_req_i    (key_req_i),
      .key_data_i   (key_data_i),
      .key_ack_o    (key_ack_o),
      .key_data_o   (key_data_o),
      .busy_o       (busy_o)
   );

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; state_req_i = 1'b0; key_req_i = 1'b0;
      state_data_i = '0; key_data_i = '0;
      step(); step();
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
      checks++; if (state_ack_o !== 1'b0) begin errors++; $display("FAIL reset_state_ack got=%b exp=0", state_ack_o); end
      checks++; if (key_ack_o !== 1'b0) begin errors++; $display("FAIL reset_key_ack got=%b exp=0", key_ack_o); end
      checks++; if (state_data_o !== 128'h0) begin errors++; $display("FAIL reset_state_data got=%h exp=0", state_data_o); end
      checks++; if (key_data_o !== 32'h0) begin errors++; $display("FAIL reset_key_data got=%h exp=0", key_data_o); end
      rst_i = 1'b0;
   endtask

   task automatic test_state(input logic [127:0] din, input logic [127:0] dexp);
      int ack_cyc;
      ack_cyc = NS + 1 + P;
      state_data_i = din;
      state_req_i  = 1'b1;
      for (int k = 1; k <= ack_cyc + 2; k++) begin
         step();
         checks++;
         if (state_ack_o !== (k == ack_cyc)) begin
            errors++; $display("FAIL state_ack cyc=%0d got=%b exp=%b", k, state_ack_o, (k == ack_cyc));
         end
         checks++;
         if (busy_o !== (k <= ack_cyc)) begin
            errors++; $display("FAIL state_busy cyc=%0d got=%b exp=%b", k, busy_o, (k <= ack_cyc));
         end
         if (k == ack_cyc) begin
            checks++;
            if (state_data_o !== dexp) begin
               errors++; $display("FAIL state_data got=%h exp=%h", state_data_o, dexp);
            end
            state_req_i = 1'b0;
         end
      end
   endtask

   task automatic test_key(input logic [31:0] din, input logic [31:0] dexp);
      int ack_cyc;
      ack_cyc = NK + 1 + P;
      key_data_i = din;
      key_req_i  = 1'b1;
      for (int k = 1; k <= ack_cyc + 2; k++) begin
         step();
         checks++;
         if (key_ack_o !== (k == ack_cyc)) begin
            errors++; $display("FAIL key_ack cyc=%0d got=%b exp=%b", k, key_ack_o, (k == ack_cyc));
         end
         checks++;
         if (state_ack_o !== 1'b0) begin
            errors++; $display("FAIL key_state_ack cyc=%0d got=%b exp=0", k, state_ack_o);
         end
         if (k == ack_cyc) begin
            checks++;
            if (key_data_o !== dexp) begin
               errors++; $display("FAIL key_data got=%h exp=%h", key_data_o, dexp);
            end
            key_req_i = 1'b0;
         end
      end
   endtask

   // Both requesters held from right after reset: state, key, state, key.
   task automatic test_back_to_back();
      int t1, t2, t3, t4;
      logic es, ek;
      t1 = NS + 1 + P;
      t2 = t1 + NK + 2 + P;
      t3 = t2 + NS + 2 + P;
      t4 = t3 + NK + 2 + P;
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      state_data_i = ZERO_IN;  key_data_i = KEY_A_IN;
      state_req_i  = 1'b1;     key_req_i  = 1'b1;
      for (int k = 1; k <= t4 + 1; k++) begin
         step();
         es = (k == t1) || (k == t3);
         ek = (k == t2) || (k == t4);
         checks++;
         if (state_ack_o !== es) begin
            errors++; $display("FAIL b2b_state_ack cyc=%0d got=%b exp=%b", k, state_ack_o, es);
         end
         checks++;
         if (key_ack_o !== ek) begin
            errors++; $display("FAIL b2b_key_ack cyc=%0d got=%b exp=%b", k, key_ack_o, ek);
         end
         if (es) begin
            checks++;
            if (state_data_o !== ZERO_OUT) begin
               errors++; $display("FAIL b2b_state_data got=%h exp=%h", state_data_o, ZERO_OUT);
            end
         end
         if (ek) begin
            checks++;
            if (key_data_o !== KEY_A_OUT) begin
               errors++; $display("FAIL b2b_key_data got=%h exp=%h", key_data_o, KEY_A_OUT);
            end
         end
         if (k == t4) begin
            state_req_i = 1'b0; key_req_i = 1'b0;
         end
      end
   endtask

   // State aborts at cycle 8; key (raised at cycle 2) is granted in the IDLE at 9.
   task automatic test_abort();
      int ka;
      logic eb;
      ka = 14 + P;
      state_data_i = SEQ_IN; key_data_i = KEY_B_IN;
      state_req_i  = 1'b1;   key_req_i  = 1'b0;
      for (int k = 1; k <= ka + 2; k++) begin
         step();
         eb = (k != 9) && (k <= ka);
         checks++;
         if (state_ack_o !== 1'b0) begin
            errors++; $display("FAIL abort_state_ack cyc=%0d got=%b exp=0", k, state_ack_o);
         end
         checks++;
         if (key_ack_o !== (k == ka)) begin
            errors++; $display("FAIL abort_key_ack cyc=%0d got=%b exp=%b", k, key_ack_o, (k == ka));
         end
         checks++;
         if (busy_o !== eb) begin
            errors++; $display("FAIL abort_busy cyc=%0d got=%b exp=%b", k, busy_o, eb);
         end
         if (k == 9) begin
            checks++;
            if (state_data_o !== ZERO_OUT) begin
               errors++; $display("FAIL abort_state_hold got=%h exp=%h", state_data_o, ZERO_OUT);
            end
         end
         if (k == ka) begin
            checks++;
            if (key_data_o !== KEY_B_OUT) begin
               errors++; $display("FAIL abort_key_data got=%h exp=%h", key_data_o, KEY_B_OUT);
            end
            key_req_i = 1'b0;
         end
         if (k == 2) key_req_i = 1'b1;
         if (k == 8) state_req_i = 1'b0;
      end
   endtask

   task automatic test_reset_mid();
      key_data_i = KEY_A_IN;
      key_req_i  = 1'b1;
      step(); step();
      rst_i = 1'b1; key_req_i = 1'b0;
      step();
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy_o); end
      checks++; if (key_ack_o !== 1'b0) begin errors++; $display("FAIL midrst_key_ack got=%b exp=0", key_ack_o); end
      checks++; if (key_data_o !== 32'h0) begin errors++; $display("FAIL midrst_key_data got=%h exp=0", key_data_o); end
      checks++; if (state_data_o !== 128'h0) begin errors++; $display("FAIL midrst_state_data got=%h exp=0", state_data_o); end
      rst_i = 1'b0;
      test_key(KEY_B_IN, KEY_B_OUT);
   endtask

   initial begin
      test_reset();
      test_state(ZERO_IN, ZERO_OUT);
      test_key(KEY_A_IN, KEY_A_OUT);
      test_state(SEQ_IN, SEQ_OUT);
      test_back_to_back();
      test_abort();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
